// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the cache-side memory interface.
//   WORD_SIZE        : default bus word width in bits
//   BLOCK_DATA_WIDTH : default cache block width in bits
//   burst_state_e    : state encoding of the block-to-beat burst FSM
// Optional feature used by importers: MEM_BURST_TIMEOUT_EN (bus stall timeout).
// -----------------------------------------------------------------------------
package cache_pkg;

  localparam int WORD_SIZE        = 32;
  localparam int BLOCK_DATA_WIDTH = 512;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BURST   = 2'd1,
    DONE    = 2'd2,
    RELEASE = 2'd3
  } burst_state_e;

  // Number of bus beats needed to move one cache block.
  function automatic int burst_beats(input int block_w, input int word_w);
    return block_w / word_w;
  endfunction

endpackage

// File: rtl/mem_burst_timeout.sv
// -----------------------------------------------------------------------------
// mem_burst_timeout
// Counts consecutive stalled burst cycles and flags expiry on the cycle in which
// the TIMEOUT_CYCLES-th consecutive stall occurs. Only used when the design is
// built with MEM_BURST_TIMEOUT_EN.
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   stall_i   : 1 when a beat is requested but not accepted this cycle
//   expired_o : 1 when this stall cycle reaches the limit
// -----------------------------------------------------------------------------
module mem_burst_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stall_i,
  output logic expired_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt_q holds the number of stalls already seen, so the current stall is
  // number cnt_q+1; expiry fires when that equals the limit.
  assign expired_o = stall_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (!stall_i || expired_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_burst_adapter.sv
// -----------------------------------------------------------------------------
// mem_burst_adapter
// Converts one cache-block request into BLOCK_DATA_WIDTH/WORD_SIZE sequential
// bus beats at addresses base+4*i (base = request address with bits [5:0]
// cleared). Fills assemble the returned words into mem_req_datain; write-backs
// send the captured block one word per beat.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   mem_req_enable/rw/addr/dataout : block request (rw=1 write-back, 0 fill)
//   mem_req_datain      : assembled fill block (held until next read beat)
//   mem_req_ready       : one-cycle completion pulse
//   mem_req_error       : completion was a stall timeout
//   bus_valid/we/addr/wdata : beat request towards memory
//   bus_ready/rdata     : beat acceptance and read data
// Build option: define MEM_BURST_TIMEOUT_EN to abort a burst after
// TIMEOUT_CYCLES consecutive stalled cycles; otherwise bursts wait forever.
// -----------------------------------------------------------------------------
module mem_burst_adapter #(
  parameter int WORD_SIZE        = cache_pkg::WORD_SIZE,
  parameter int BLOCK_DATA_WIDTH = cache_pkg::BLOCK_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES   = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        mem_req_enable,
  input  logic                        mem_req_rw,
  input  logic [WORD_SIZE-1:0]        mem_req_addr,
  input  logic [BLOCK_DATA_WIDTH-1:0] mem_req_dataout,
  output logic [BLOCK_DATA_WIDTH-1:0] mem_req_datain,
  output logic                        mem_req_ready,
  output logic                        mem_req_error,
  output logic                        bus_valid,
  output logic                        bus_we,
  output logic [WORD_SIZE-1:0]        bus_addr,
  output logic [WORD_SIZE-1:0]        bus_wdata,
  input  logic                        bus_ready,
  input  logic [WORD_SIZE-1:0]        bus_rdata
);

  import cache_pkg::*;

  localparam int BEATS  = burst_beats(BLOCK_DATA_WIDTH, WORD_SIZE);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  burst_state_e                state_q, state_d;
  logic [BEAT_W-1:0]           beat_q, beat_d;
  logic [WORD_SIZE-1:0]        base_q;
  logic                        rw_q;
  logic [BLOCK_DATA_WIDTH-1:0] wblock_q;
  logic [BLOCK_DATA_WIDTH-1:0] datain_q;
  logic                        in_burst;
  logic                        beat_accept;
  logic                        last_beat;
  logic                        timeout;

  assign in_burst    = (state_q == BURST);
  assign beat_accept = in_burst && bus_ready;
  assign last_beat   = (beat_q == BEAT_W'(BEATS - 1));

`ifdef MEM_BURST_TIMEOUT_EN
  logic err_q;

  mem_burst_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .stall_i  (in_burst && !bus_ready),
    .expired_o(timeout)
  );

  // Remembers that the burst ended by timeout so DONE can flag the error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= timeout;
    end
  end

  assign mem_req_error = (state_q == DONE) && err_q;
`else
  assign timeout       = 1'b0;
  assign mem_req_error = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (mem_req_enable) begin
          state_d = BURST;
          beat_d  = '0;
        end
      end
      BURST: begin
        if (timeout) begin
          state_d = DONE;
        end else if (bus_ready) begin
          if (last_beat) begin
            state_d = DONE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      DONE:    state_d = RELEASE;
      // Wait for enable to drop so a held request is served only once.
      RELEASE: if (!mem_req_enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      base_q   <= '0;
      rw_q     <= 1'b0;
      wblock_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      // Request inputs are only sampled on the IDLE->BURST edge.
      if (state_q == IDLE && mem_req_enable) begin
        base_q   <= {mem_req_addr[WORD_SIZE-1:6], 6'b0};
        rw_q     <= mem_req_rw;
        wblock_q <= mem_req_dataout;
      end
    end
  end

  // Fill assembly: each accepted read beat lands in its own word; a timeout
  // clears the words that never arrived (current beat and later).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      datain_q <= '0;
    end else begin
      for (int i = 0; i < BEATS; i++) begin
        if (beat_accept && !rw_q && beat_q == BEAT_W'(i)) begin
          datain_q[i*WORD_SIZE +: WORD_SIZE] <= bus_rdata;
        end else if (timeout && !rw_q && beat_q <= BEAT_W'(i)) begin
          datain_q[i*WORD_SIZE +: WORD_SIZE] <= '0;
        end
      end
    end
  end

  assign mem_req_datain = datain_q;
  assign mem_req_ready  = (state_q == DONE);
  assign bus_valid      = in_burst;
  assign bus_we         = in_burst && rw_q;
  assign bus_addr       = in_burst ? (base_q + WORD_SIZE'({beat_q, 2'b00})) : '0;
  assign bus_wdata      = (in_burst && rw_q) ? wblock_q[int'(beat_q)*WORD_SIZE +: WORD_SIZE] : '0;

endmodule
